// File: rtl/ace_ack_demux.sv
// Returns RACK/WACK pulses to the master port that sourced the matching R-last/B beat.
// Each channel keeps an in-order FIFO of port indices; acks retire strictly in response order.

module ace_ack_chan #(
  parameter int unsigned NoMstPorts  = 32'd4,
  parameter int unsigned MaxAcks     = 32'd8,
  parameter bit          RegAck      = 1'b0,
  parameter int unsigned SelectWidth = 2,
  parameter int unsigned CntWidth    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   hs_i,
  input  logic [SelectWidth-1:0] sel_i,
  input  logic                   ack_i,
  output logic [NoMstPorts-1:0]  mst_ack_o,
  output logic                   stall_o,
  output logic [CntWidth-1:0]    pending_o,
  output logic                   err_o
);
  localparam int unsigned PtrWidth = (MaxAcks > 1) ? $clog2(MaxAcks) : 1;

  logic [SelectWidth-1:0] r_mem [MaxAcks];
  logic [PtrWidth-1:0]    r_wr_ptr;
  logic [PtrWidth-1:0]    r_rd_ptr;
  logic [CntWidth-1:0]    r_cnt;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic [SelectWidth-1:0] w_sel;
  logic [SelectWidth-1:0] w_head;
  logic [NoMstPorts-1:0]  w_onehot;

  // Single-port configurations store index 0 regardless of what the demux drives.
  if (NoMstPorts > 1) begin : g_sel
    assign w_sel = sel_i;
  end else begin : g_nosel
    assign w_sel = '0;
  end

  assign w_full   = (r_cnt == CntWidth'(MaxAcks));
  assign w_empty  = (r_cnt == '0);
  assign w_pop    = ack_i && !w_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is accepted.
  assign w_push   = hs_i && (!w_full || w_pop);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_onehot = w_pop ? (NoMstPorts'(1) << w_head) : '0;

  assign err_o     = (hs_i && w_full && !w_pop) || (ack_i && w_empty);
  assign stall_o   = w_full;
  assign pending_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrWidth'(MaxAcks - 1)) ? '0 : r_wr_ptr + PtrWidth'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrWidth'(MaxAcks - 1)) ? '0 : r_rd_ptr + PtrWidth'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  if (RegAck) begin : g_reg_ack
    logic [NoMstPorts-1:0] r_ack;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_ack <= '0;
      else         r_ack <= w_onehot;
    end
    assign mst_ack_o = r_ack;
  end else begin : g_comb_ack
    assign mst_ack_o = w_onehot;
  end
endmodule

module ace_ack_demux #(
  parameter int unsigned NoMstPorts  = 32'd4,
  parameter int unsigned MaxAcks     = 32'd8,
  parameter bit          RegAck      = 1'b0,
  parameter int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
  parameter int unsigned CntWidth    = $clog2(MaxAcks + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   b_hs_i,
  input  logic [SelectWidth-1:0] b_sel_i,
  input  logic                   r_last_hs_i,
  input  logic [SelectWidth-1:0] r_sel_i,
  input  logic                   slv_wack_i,
  input  logic                   slv_rack_i,
  output logic [NoMstPorts-1:0]  mst_wack_o,
  output logic [NoMstPorts-1:0]  mst_rack_o,
  output logic                   b_stall_o,
  output logic                   r_stall_o,
  output logic [CntWidth-1:0]    w_pending_o,
  output logic [CntWidth-1:0]    r_pending_o,
  output logic                   err_o
);
  logic w_b_err;
  logic w_r_err;
  logic r_err;

  ace_ack_chan #(
    .NoMstPorts(NoMstPorts), .MaxAcks(MaxAcks), .RegAck(RegAck),
    .SelectWidth(SelectWidth), .CntWidth(CntWidth)
  ) i_wr_chan (
    .clk_i(clk_i), .rst_ni(rst_ni), .hs_i(b_hs_i), .sel_i(b_sel_i), .ack_i(slv_wack_i),
    .mst_ack_o(mst_wack_o), .stall_o(b_stall_o), .pending_o(w_pending_o), .err_o(w_b_err)
  );

  ace_ack_chan #(
    .NoMstPorts(NoMstPorts), .MaxAcks(MaxAcks), .RegAck(RegAck),
    .SelectWidth(SelectWidth), .CntWidth(CntWidth)
  ) i_rd_chan (
    .clk_i(clk_i), .rst_ni(rst_ni), .hs_i(r_last_hs_i), .sel_i(r_sel_i), .ack_i(slv_rack_i),
    .mst_ack_o(mst_rack_o), .stall_o(r_stall_o), .pending_o(r_pending_o), .err_o(w_r_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else         r_err <= r_err | w_b_err | w_r_err;
  end
  assign err_o = r_err;

`ifndef SYNTHESIS
  if (NoMstPorts > 1) begin : g_sel_chk
    a_b_sel: assert property (@(posedge clk_i) disable iff (!rst_ni)
      b_hs_i |-> (32'(b_sel_i) < NoMstPorts));
    a_r_sel: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_last_hs_i |-> (32'(r_sel_i) < NoMstPorts));
  end
  // While stalled, a handshake is only tolerable if a same-cycle ack frees the slot.
  a_b_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (b_hs_i && b_stall_o) |-> slv_wack_i);
  a_r_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_last_hs_i && r_stall_o) |-> slv_rack_i);
`endif
endmodule

// File: doc/ace_ack_demux.md
Name: ace_ack_demux

Overview:
Routes ACE read/write acknowledge pulses (RACK/WACK) from the single slave port of an ACE demux back to the master port that delivered the matching R-last or B beat.
- Keeps one in-order FIFO of port indices per channel, so acks retire in response order across any number of master ports.
- Back-pressures response delivery when the FIFO is full.
- Sits next to the ACE demux, fed by its slave-side B/R handshake events.

Parameters:
NoMstPorts, 32'd4, number of master ports (>=1).
MaxAcks, 32'd8, outstanding un-acked responses tracked per channel (FIFO depth, >=2).
RegAck, 1'b0, 1 = register mst_*ack_o (+1 cycle latency); 0 = combinational from slv_*ack_i.
SelectWidth, (NoMstPorts>1)?$clog2(NoMstPorts):1, dependent, do not override.
CntWidth, $clog2(MaxAcks+1), dependent, do not override.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
b_hs_i  in  1  B handshake completed on slave port this cycle
b_sel_i  in  SelectWidth  master port that sourced that B
r_last_hs_i  in  1  R handshake with last=1 completed on slave port this cycle
r_sel_i  in  SelectWidth  master port that sourced that R burst
slv_wack_i  in  1  WACK pulse from upstream master
slv_rack_i  in  1  RACK pulse from upstream master
mst_wack_o  out  NoMstPorts  one-hot WACK toward master ports
mst_rack_o  out  NoMstPorts  one-hot RACK toward master ports
b_stall_o  out  1  write FIFO full; demux must hold B ready low
r_stall_o  out  1  read FIFO full; demux must hold R-last ready low
w_pending_o  out  CntWidth  un-acked B count
r_pending_o  out  CntWidth  un-acked R-last count
err_o  out  1  sticky protocol error

Behaviour:
- One clock. Reset is asynchronous, active-low (rst_ni).
- Reset values: FIFOs empty, counts 0, mst_wack_o/mst_rack_o 0, b_stall_o/r_stall_o 0, err_o 0.
- Write and read paths are identical and fully independent. Described below for the write path.
- Push:
  - b_hs_i=1 and FIFO not full: write b_sel_i at wr_ptr; wr_ptr increments and wraps at MaxAcks-1 -> 0.
  - b_hs_i=1 while full (b_stall_o ignored): entry dropped, err_o set.
- Pop:
  - slv_wack_i=1 and FIFO not empty: pop head; drive mst_wack_o[head]=1 for exactly one cycle.
  - Timing of that pulse: same cycle when RegAck=0; next cycle when RegAck=1.
  - rd_ptr wraps the same way as wr_ptr.
- Ack ordering: an ack may only retire a response handshaked in an earlier cycle. slv_wack_i=1 with an empty FIFO at cycle start is illegal, even if b_hs_i=1 in the same cycle.
  - Result: no pulse emitted, FIFO unchanged except for the push, err_o set.
- Simultaneous push and pop on a non-empty FIFO:
  - Both happen; count unchanged.
  - Legal when full: the pop frees the slot in the same cycle.
  - b_stall_o is still asserted that cycle, because it is registered from count==MaxAcks.
- b_stall_o = (count==MaxAcks), taken from registered count. A full FIFO therefore stalls at least one cycle.
- w_pending_o = registered count, range 0..MaxAcks.
- At most one bit of mst_wack_o is high per cycle. Outputs are always one-hot or zero.
- err_o is sticky until reset.
- Reset mid-operation: all pending entries are discarded. Registered ack outputs clear asynchronously; no pulse is emitted after reset release.
- NoMstPorts=1: selects are ignored, index is always 0, and the block reduces to a counter plus a pass-through.
- Assertions (non-synthesis):
  - sel < NoMstPorts whenever a handshake is valid.
  - No handshake while stall is asserted.

Test Plan:
1. RegAck=0, NoMstPorts=4. B handshakes from ports 2,0,3 in cycles 1,2,3; WACK in cycles 5,6,7 -> mst_wack_o = 4'b0100, 4'b0001, 4'b1000 in cycles 5,6,7; w_pending_o steps 3->2->1->0.
2. RegAck=1. R-last from port 1 in cycle 1, RACK in cycle 3 -> mst_rack_o=4'b0010 in cycle 4 only; r_pending_o 1->0 at cycle 4.
3. MaxAcks=8. 8 B handshakes with no WACK -> b_stall_o=1 the cycle after the 8th. Then WACK and B together -> count stays 8, popped index emitted, new index queued. Drain 8 WACKs -> indices returned in FIFO order, including entries past the wrap point.
4. slv_rack_i=1 and r_last_hs_i=1 in the same cycle with an empty FIFO -> no mst_rack_o pulse, err_o=1 and sticky, r_pending_o=1.
5. Interleaved paths: B from port 3 and R-last from port 1 in the same cycle, then WACK and RACK in the same cycle -> mst_wack_o=4'b1000 and mst_rack_o=4'b0010 together, with no cross-talk.
6. Three entries pending, rst_ni pulsed low mid-stream -> all outputs 0 immediately. After release, a WACK with no new B -> err_o=1 and no pulse.
